// File: rtl/dmem_responder.sv
// Data-memory responder: word-addressed load/store target behind valid/ready request and response channels.
// Latency: a request accepted in cycle c gets resp_valid in cycle c+WAIT_CYCLES+1.
// Backpressure: one request is outstanding at a time. req_ready is high only in IDLE. The response is held until resp_ready.
//
// Parameters: DEPTH_WORDS (power of two, >= 2), WAIT_CYCLES (0..15).
// Ports: clk/reset (async, active-high); req_valid/req_ready/req_write/req_addr/req_wdata;
//        resp_valid/resp_ready/resp_rdata/resp_err; busy (FSM not in IDLE).
// Build option: DMEM_ERR_CHECK_EN enables misaligned/out-of-range error detection.
//        Without it, resp_err is 0 and addresses wrap modulo DEPTH_WORDS.

module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state;
    logic [3:0]  wait_cnt;
    logic        r_write;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] mem [DEPTH_WORDS];

    logic          accept;
    logic          commit_from_req;
    logic          commit_from_wait;
    logic          commit;
    logic          c_write;
    logic [31:0]   c_addr;
    logic [31:0]   c_wdata;
    logic [AW-1:0] c_idx;
    logic          c_err;
    logic [31:0]   c_rdata;

    assign accept           = (state == S_IDLE) && req_valid;
    // With no wait states the access commits on the acceptance edge itself,
    // straight from the request inputs rather than the captured copy.
    assign commit_from_req  = accept && (WAIT_CYCLES == 0);
    assign commit_from_wait = (state == S_WAIT) && (wait_cnt == 4'd1);
    assign commit           = (commit_from_req || commit_from_wait) && !reset;

    always_comb begin
        c_write = r_write;
        c_addr  = r_addr;
        c_wdata = r_wdata;
        if (commit_from_req) begin
            c_write = req_write;
            c_addr  = req_addr;
            c_wdata = req_wdata;
        end
    end

    assign c_idx = c_addr[AW+1:2];

`ifdef DMEM_ERR_CHECK_EN
    assign c_err = (c_addr[1:0] != 2'b00) || ((c_addr >> (AW + 2)) != 32'd0);
`else
    assign c_err = 1'b0;
    // Byte-offset and above-range bits do not take part in addressing here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{c_addr[1:0], c_addr[31:AW+2]};
`endif

    // Stores and errored accesses report zero data.
    assign c_rdata = (c_write || c_err) ? 32'd0 : mem[c_idx];

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (commit && c_write && !c_err) begin
            mem[c_idx] <= c_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            wait_cnt   <= 4'd0;
            r_write    <= 1'b0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        r_write   <= req_write;
                        r_addr    <= req_addr;
                        r_wdata   <= req_wdata;
                        wait_cnt  <= 4'(WAIT_CYCLES);
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            state      <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= c_rdata;
                            resp_err   <= c_err;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    // The counter counts WAIT_CYCLES..1. The last WAIT cycle commits.
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= c_rdata;
                        resp_err   <= c_err;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state      <= S_IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: instance 0 has WAIT_CYCLES=2 and instance 1 has WAIT_CYCLES=0.
// A word-array reference model predicts data and error flags. Response timing is checked cycle by cycle.
// Inputs are driven on negedge. Outputs are sampled on negedge or #1 after an async reset.

module tb_dmem_responder;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_write  [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];
    logic        busy       [2];

    logic [31:0] mem_m [2][DEPTH];
    bit          kn    [2][DEPTH];

    int n_checks;
    int n_fail;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) u_dut_w2 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]), .busy(busy[0])
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]), .busy(busy[1])
    );

    function automatic int wc(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input int d, input string tag);
        check({tag, "_req_ready"},  32'(req_ready[d]),  32'd1);
        check({tag, "_resp_valid"}, 32'(resp_valid[d]), 32'd0);
        check({tag, "_busy"},       32'(busy[d]),       32'd0);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        int sel;
        sel = $urandom_range(0, 9);
        a = 32'($urandom_range(0, 15)) << 2;
        if (sel == 7) a = a + 32'h400;                       // above range
        else if (sel == 8) a = a | 32'($urandom_range(1, 3)); // misaligned
        else if (sel == 9) a = $urandom();
        return a;
    endfunction

    // One full transaction with cycle-accurate checks of the handshake timing.
    task automatic txn(input int d, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wd, input int stall,
                       output logic [31:0] rd, output logic er);
        int          idx;
        logic [31:0] exp_rd;
        logic        exp_er;
        bit          known;
        idx = int'((addr >> 2) % DEPTH);
`ifdef DMEM_ERR_CHECK_EN
        exp_er = (addr[1:0] != 2'b00) || (addr >= 32'(4 * DEPTH));
`else
        exp_er = 1'b0;
`endif
        known  = 1'b1;
        exp_rd = 32'd0;
        if (!wr && !exp_er) begin
            exp_rd = mem_m[d][idx];
            known  = kn[d][idx];
        end

        @(negedge clk);
        check("accept_req_ready", 32'(req_ready[d]), 32'd1);
        req_valid[d] = 1'b1;
        req_write[d] = wr;
        req_addr[d]  = addr;
        req_wdata[d] = wd;
        @(posedge clk);
        #1;
        // Garbage on the request channel must be ignored outside IDLE.
        req_valid[d]  = 1'($urandom_range(0, 1));
        req_write[d]  = 1'($urandom);
        req_addr[d]   = $urandom();
        req_wdata[d]  = $urandom();
        resp_ready[d] = (wc(d) > 0);
        for (int k = 0; k < wc(d); k++) begin
            @(negedge clk);
            check("wait_resp_valid", 32'(resp_valid[d]), 32'd0);
            check("wait_req_ready",  32'(req_ready[d]),  32'd0);
            check("wait_busy",       32'(busy[d]),       32'd1);
            if (k == wc(d) - 1) resp_ready[d] = 1'b0;
        end
        @(negedge clk);
        check("resp_valid", 32'(resp_valid[d]), 32'd1);
        check("resp_req_ready", 32'(req_ready[d]), 32'd0);
        check("resp_err", 32'(resp_err[d]), 32'(exp_er));
        if (known) check("resp_rdata", resp_rdata[d], exp_rd);
        rd = resp_rdata[d];
        er = resp_err[d];
        resp_ready[d] = 1'b0;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("hold_resp_valid", 32'(resp_valid[d]), 32'd1);
            check("hold_req_ready",  32'(req_ready[d]),  32'd0);
            check("hold_err",        32'(resp_err[d]),   32'(exp_er));
            if (known) check("hold_rdata", resp_rdata[d], exp_rd);
        end
        req_valid[d]  = 1'b0;
        resp_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        resp_ready[d] = 1'b0;
        @(negedge clk);
        check_idle_outputs(d, "post_hs");

        if (wr && !exp_er) begin
            mem_m[d][idx] = wd;
            kn[d][idx]    = 1'b1;
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] base;
        int          acc;

        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_valid[d]  = 1'b0;
            req_write[d]  = 1'b0;
            req_addr[d]   = 32'd0;
            req_wdata[d]  = 32'd0;
            resp_ready[d] = 1'b0;
            for (int i = 0; i < DEPTH; i++) kn[d][i] = 1'b0;
        end

        #1;
        for (int d = 0; d < 2; d++) begin
            check_idle_outputs(d, "reset");
            check("reset_rdata", resp_rdata[d], 32'd0);
            check("reset_err", 32'(resp_err[d]), 32'd0);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16; i++)
                txn(d, 1'b1, 32'(i * 4), $urandom(), 0, rd, er);

        // Store then load with two wait states.
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 0, rd, er);
        check("store_rdata_zero", rd, 32'd0);
        txn(0, 1'b0, 32'h10, 32'd0, 0, rd, er);
        check("load_after_store", rd, 32'hDEADBEEF);

        // Five cycles of response backpressure.
        txn(0, 1'b0, 32'h10, 32'd0, 5, rd, er);
        check("backpressure_rdata", rd, 32'hDEADBEEF);

        // Reset in the middle of WAIT discards the uncommitted store.
        txn(0, 1'b1, 32'h20, 32'hA5A50001, 0, rd, er);
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_addr[0]  = 32'h20;
        req_wdata[0] = 32'h0BAD0BAD;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        check("midwait_busy", 32'(busy[0]), 32'd1);
        reset = 1'b1;
        #1;
        check_idle_outputs(0, "async_reset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs(0, "after_reset");
        txn(0, 1'b0, 32'h20, 32'd0, 0, rd, er);
        check("reset_discards_store", rd, 32'hA5A50001);

        // Zero wait states: single-cycle response, then back-to-back requests.
        txn(1, 1'b1, 32'h0, 32'hCAFEF00D, 0, rd, er);
        txn(1, 1'b0, 32'h0, 32'd0, 0, rd, er);
        check("w0_load", rd, 32'hCAFEF00D);
        acc = 0;
        @(negedge clk);
        req_valid[1]  = 1'b1;
        req_write[1]  = 1'b0;
        req_addr[1]   = 32'h0;
        resp_ready[1] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            if (req_ready[1]) acc++;
            check("b2b_resp_valid", 32'(resp_valid[1]), 32'(i % 2));
            if (i % 2 == 1) check("b2b_rdata", resp_rdata[1], 32'hCAFEF00D);
            if (i == 9) req_valid[1] = 1'b0;
        end
        @(posedge clk);
        #1;
        resp_ready[1] = 1'b0;
        check("b2b_accept_count", 32'(acc), 32'd5);
        @(negedge clk);
        check_idle_outputs(1, "b2b_end");

`ifdef DMEM_ERR_CHECK_EN
        base = mem_m[0][0];
        txn(0, 1'b1, 32'h402, 32'h000055AA, 0, rd, er);
        check("err_store_flag", 32'(er), 32'd1);
        txn(0, 1'b0, 32'h400, 32'd0, 0, rd, er);
        check("err_load_flag", 32'(er), 32'd1);
        check("err_load_rdata", rd, 32'd0);
        txn(0, 1'b0, 32'h0, 32'd0, 0, rd, er);
        check("err_store_no_effect", rd, base);
`else
        base = 32'h00001234;
        txn(0, 1'b1, 32'h400, base, 0, rd, er);
        txn(0, 1'b0, 32'h000, 32'd0, 0, rd, er);
        check("wrap_rdata", rd, 32'h00001234);
        check("wrap_err", 32'(er), 32'd0);
`endif

        for (int i = 0; i < 60; i++)
            txn(i % 2, 1'($urandom), rand_addr(), $urandom(), $urandom_range(0, 3), rd, er);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
